// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel registered mux with round-robin or fixed-priority arbitration and valid/ready handshakes.
module arb_mux_n #(
  parameter int WIDTH = 64,
  parameter int N = 4,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int SW = $clog2(N);
  logic [WIDTH-1:0] ch [N];
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0] src_q, src_d, ptr_q, ptr_d, winner, idx;
  logic valid_q, valid_d, accept, any, xfer;
  // Scan from the lowest priority up so the highest-priority requester is written last.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SW'(MODE != 0 ? k - 1 : (int'(ptr_q) + k) % N);
      if (in_valid[idx]) winner = idx;
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) ch[i] = in_data[i*WIDTH +: WIDTH];
    accept = !valid_q || out_ready;
    any = |in_valid;
    xfer = accept && any && !reset;
    for (int i = 0; i < N; i++) in_ready[i] = xfer && (winner == SW'(i));
    valid_d = accept ? any : valid_q;
    data_d = xfer ? ch[winner] : data_q;
    src_d = xfer ? winner : src_q;
    ptr_d = (xfer && MODE == 0) ? winner : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      src_q <= '0;
      ptr_q <= SW'(N - 1);
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_data = data_q;
  assign out_src = src_q;
  assign out_valid = valid_q;
endmodule
